// File: rtl/ghost_pkg.sv
// Shared types and constants for the ghost sprite renderer.
package ghost_pkg;

    // Facing direction; also forms the direction field of the sprite ROM address
    typedef enum logic [1:0] {
        DIR_RIGHT = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_UP    = 2'b10,
        DIR_DOWN  = 2'b11
    } dir_t;

    // Animation frame codes from the ghost FSM; anything other than B shows frame A
    localparam logic [1:0] CODE_FRAME_A = 2'b00;
    localparam logic [1:0] CODE_FRAME_B = 2'b01;

    // Body colour selectors
    localparam logic [1:0] COLOR_RED    = 2'd0;
    localparam logic [1:0] COLOR_PINK   = 2'd1;
    localparam logic [1:0] COLOR_CYAN   = 2'd2;
    localparam logic [1:0] COLOR_ORANGE = 2'd3;

    // Palette colours (24-bit RGB)
    localparam logic [23:0] RGB_BLACK       = 24'h000000;
    localparam logic [23:0] RGB_RED         = 24'hFF0000;
    localparam logic [23:0] RGB_PINK        = 24'hFFB8FF;
    localparam logic [23:0] RGB_CYAN        = 24'h00FFFF;
    localparam logic [23:0] RGB_ORANGE      = 24'hFFB852;
    localparam logic [23:0] RGB_WHITE       = 24'hFFFFFF;
    localparam logic [23:0] RGB_PUPIL       = 24'h2121DE;
    localparam logic [23:0] RGB_FRIGHT_BLUE = 24'h2121FF;
    localparam logic [23:0] RGB_FRIGHT_FACE = 24'hFFB8AE;

    // Frightened-ending blink phases
    typedef enum logic [1:0] {
        BLINK_STEADY = 2'd0,
        BLINK_BLUE   = 2'd1,
        BLINK_WHITE  = 2'd2
    } blink_state_t;

    // Per-pixel colouring context carried down the pipeline with each pixel
    typedef struct packed {
        logic [1:0] color_id;
        logic       frightened;
        logic       white;
    } pal_ctx_t;

    // Normal (non-frightened) body colour
    function automatic logic [23:0] body_rgb_f(input logic [1:0] color_id);
        logic [23:0] rgb;
        case (color_id)
            COLOR_RED:    rgb = RGB_RED;
            COLOR_PINK:   rgb = RGB_PINK;
            COLOR_CYAN:   rgb = RGB_CYAN;
            default:      rgb = RGB_ORANGE;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/ghost_blink_timer.sv
// Frightened-ending blink timer: counts video frames and alternates blue/white body phases.
module ghost_blink_timer
    import ghost_pkg::*;
#(
    parameter int unsigned BLINK_FRAMES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic frame_start_i,
    input  logic frightened_end_i,
    output logic blink_white_o
);

    localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    blink_state_t     state_q;
    logic [CNT_W-1:0] cnt_q;

    // Phase FSM advanced once per frame; output white flag registered with the state
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= BLINK_STEADY;
            cnt_q         <= '0;
            blink_white_o <= 1'b0;
        end else if (frame_start_i) begin
            if (!frightened_end_i) begin
                state_q       <= BLINK_STEADY;
                cnt_q         <= '0;
                blink_white_o <= 1'b0;
            end else begin
                case (state_q)
                    BLINK_STEADY: begin
                        state_q       <= BLINK_BLUE;
                        cnt_q         <= '0;
                        blink_white_o <= 1'b0;
                    end
                    BLINK_BLUE: begin
                        if (cnt_q == CNT_LAST) begin
                            state_q       <= BLINK_WHITE;
                            cnt_q         <= '0;
                            blink_white_o <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    BLINK_WHITE: begin
                        if (cnt_q == CNT_LAST) begin
                            state_q       <= BLINK_BLUE;
                            cnt_q         <= '0;
                            blink_white_o <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q       <= BLINK_STEADY;
                        cnt_q         <= '0;
                        blink_white_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/ghost_sprite_renderer.sv
// Per-pixel ghost sprite renderer: frame-latched ghost state, hit test, sprite ROM fetch, palette.
// Optional feature macro: GHOST_MIRROR_EN (left-facing art mirrored from right-facing rows).
// Pipeline: pix_valid sampled at edge N -> rom_addr at N, ROM data during N+1..N+2, outputs at N+2.
module ghost_sprite_renderer
    import ghost_pkg::*;
#(
    parameter int unsigned SPRITE_W     = 16,
    parameter int unsigned SPRITE_H     = 16,
    parameter int unsigned COORD_W      = 10,
    parameter int unsigned BLINK_FRAMES = 8
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     frame_start,
    input  logic [1:0]                               ghost_code,
    input  logic [COORD_W-1:0]                       ghost_x,
    input  logic [COORD_W-1:0]                       ghost_y,
    input  logic [1:0]                               ghost_dir,
    input  logic [1:0]                               ghost_color_id,
    input  logic                                     frightened,
    input  logic                                     frightened_end,
    input  logic                                     pix_valid,
    input  logic [COORD_W-1:0]                       draw_x,
    input  logic [COORD_W-1:0]                       draw_y,
    output logic [$clog2(SPRITE_W*SPRITE_H)+2:0]     rom_addr,
    input  logic [1:0]                               rom_data,
    output logic                                     out_valid,
    output logic                                     ghost_hit,
    output logic [23:0]                              ghost_rgb
);

    localparam int unsigned COL_W  = $clog2(SPRITE_W);
    localparam int unsigned ROW_W  = $clog2(SPRITE_H);
    localparam int unsigned ADDR_W = $clog2(SPRITE_W*SPRITE_H) + 3;
    localparam int unsigned DIFF_W = COORD_W + 1;

    // Frame-latched ghost state
    logic [1:0]         code_q;
    logic [COORD_W-1:0] sx_q;
    logic [COORD_W-1:0] sy_q;
    dir_t               dir_q;
    logic [1:0]         color_q;
    logic               fright_q;
    logic               fend_q;

    logic               blink_white;

    // S0 combinational hit test and address build
    logic [DIFF_W-1:0]  dx_c;
    logic [DIFF_W-1:0]  dy_c;
    logic               hit0_c;
    logic [COL_W-1:0]   col_c;
    dir_t               dir_field_c;
    logic               frame_b_c;
    logic [ADDR_W-1:0]  rom_addr_d;
    pal_ctx_t           ctx0_c;

    // Pipeline stage registers
    logic               v1_q, v2_q;
    logic               hit1_q, hit2_q;
    pal_ctx_t           ctx1_q, ctx2_q;

    // S2 next values
    logic               ghost_hit_d;
    logic [23:0]        ghost_rgb_d;

    // Palette index -> RGB under the pixel's colouring context
    function automatic logic [23:0] palette_f(input logic [1:0] idx, input pal_ctx_t ctx);
        logic [23:0] rgb;
        rgb = RGB_BLACK;
        case (idx)
            2'd1: begin
                if (ctx.frightened) rgb = ctx.white ? RGB_WHITE : RGB_FRIGHT_BLUE;
                else                rgb = body_rgb_f(ctx.color_id);
            end
            2'd2:    rgb = ctx.frightened ? RGB_FRIGHT_FACE : RGB_WHITE;
            2'd3:    rgb = ctx.frightened ? RGB_FRIGHT_FACE : RGB_PUPIL;
            default: rgb = RGB_BLACK;
        endcase
        return rgb;
    endfunction

    ghost_blink_timer #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_blink (
        .clk              (clk),
        .reset            (reset),
        .frame_start_i    (frame_start),
        .frightened_end_i (frightened_end),
        .blink_white_o    (blink_white)
    );

    // Shadow registers: sampled only at the start of vertical blank
    always_ff @(posedge clk) begin
        if (!reset) begin
            code_q   <= '0;
            sx_q     <= '0;
            sy_q     <= '0;
            dir_q    <= DIR_RIGHT;
            color_q  <= '0;
            fright_q <= 1'b0;
            fend_q   <= 1'b0;
        end else if (frame_start) begin
            code_q   <= ghost_code;
            sx_q     <= ghost_x;
            sy_q     <= ghost_y;
            dir_q    <= dir_t'(ghost_dir);
            color_q  <= ghost_color_id;
            fright_q <= frightened;
            fend_q   <= frightened_end;
        end
    end

    // S0: sprite-relative offsets, bounds test and ROM address
    always_comb begin
        dx_c        = {1'b0, draw_x} - {1'b0, sx_q};
        dy_c        = {1'b0, draw_y} - {1'b0, sy_q};
        hit0_c      = pix_valid && !dx_c[DIFF_W-1] && !dy_c[DIFF_W-1]
                      && (dx_c < DIFF_W'(SPRITE_W)) && (dy_c < DIFF_W'(SPRITE_H));
        col_c       = dx_c[COL_W-1:0];
        dir_field_c = dir_q;
`ifdef GHOST_MIRROR_EN
        if (dir_q == DIR_LEFT) begin
            col_c       = COL_W'(SPRITE_W - 1) - dx_c[COL_W-1:0];
            dir_field_c = DIR_RIGHT;
        end
`endif
        frame_b_c   = (code_q == CODE_FRAME_B);
        rom_addr_d  = hit0_c ? {frame_b_c, dir_field_c, dy_c[ROW_W-1:0], col_c} : '0;
        ctx0_c.color_id   = color_q;
        ctx0_c.frightened = fright_q;
        ctx0_c.white      = fend_q && blink_white;
    end

    // S2: final hit and colour from the returned ROM index
    always_comb begin
        ghost_hit_d = v2_q && hit2_q && (rom_data != 2'd0);
        ghost_rgb_d = ghost_hit_d ? palette_f(rom_data, ctx2_q) : RGB_BLACK;
    end

    // Pixel pipeline: address issue, ROM wait, output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            rom_addr  <= '0;
            v1_q      <= 1'b0;
            hit1_q    <= 1'b0;
            ctx1_q    <= '0;
            v2_q      <= 1'b0;
            hit2_q    <= 1'b0;
            ctx2_q    <= '0;
            out_valid <= 1'b0;
            ghost_hit <= 1'b0;
            ghost_rgb <= '0;
        end else begin
            rom_addr  <= rom_addr_d;
            v1_q      <= pix_valid;
            hit1_q    <= hit0_c;
            ctx1_q    <= ctx0_c;
            v2_q      <= v1_q;
            hit2_q    <= hit1_q;
            ctx2_q    <= ctx1_q;
            out_valid <= v2_q;
            ghost_hit <= ghost_hit_d;
            ghost_rgb <= ghost_rgb_d;
        end
    end

endmodule
